// File: rtl/add_sub_normalize_round_if.sv
// add_sub_normalize_round_if
// Bundles the upstream adder-result handshake and the downstream packed-result
// handshake of the normalize/round stage.
//   in_valid / in_ready       : upstream handshake
//   sum, carry                : adder magnitude and carry-out
//   exponent_base             : larger-operand exponent from alignment
//   result_sign               : sign of the result
//   out_valid / out_ready     : downstream handshake
//   result                    : packed {sign, exponent, fraction}
//   overflow, underflow, zero : status flags, qualified by out_valid
// master = upstream/downstream environment, slave = the normalize/round block.
`timescale 1ns/1ps
interface add_sub_normalize_round_if #(
    parameter int ExponentSize = 8,
    parameter int FractionSize = 23,
    parameter int RoundingSize = FractionSize + 4
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [RoundingSize-1:0]              sum;
    logic                                 carry;
    logic [ExponentSize-1:0]              exponent_base;
    logic                                 result_sign;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [ExponentSize+FractionSize:0]   result;
    logic                                 overflow;
    logic                                 underflow;
    logic                                 zero;

    modport master (
        output in_valid, sum, carry, exponent_base, result_sign, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, zero
    );

    modport slave (
        input  in_valid, sum, carry, exponent_base, result_sign, out_ready,
        output in_ready, out_valid, result, overflow, underflow, zero
    );
endinterface

// File: rtl/add_sub_normalize_round.sv
// add_sub_normalize_round
// Two-stage pipeline after a floating-point add/sub magnitude adder.
// Stage A normalizes the raw adder output (carry-out shift or leading-zero
// shift), stage B rounds to nearest-even and packs the IEEE-754 word.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears valids, result and flags
//   bus   : add_sub_normalize_round_if.slave (handshakes, operands, result)
`timescale 1ns/1ps
module add_sub_normalize_round #(
    parameter int ExponentSize = 8,
    parameter int FractionSize = 23,
    parameter int RoundingSize = FractionSize + 4
) (
    input logic clk,
    input logic rst_n,
    add_sub_normalize_round_if.slave bus
);
    localparam int ExpWidth    = ExponentSize + 1;
    localparam int SigWidth    = FractionSize + 1;
    localparam int LzcWidth    = $clog2(RoundingSize + 1);
    localparam int ResultWidth = ExponentSize + FractionSize + 1;
    localparam logic [ExpWidth-1:0] ExpAllOnes = {1'b0, {ExponentSize{1'b1}}};

    logic                     adv_a;
    logic                     adv_b;

    logic                     a_valid;
    logic                     a_sign;
    logic                     a_zero;
    logic                     a_under;
    logic [RoundingSize-1:0]  a_norm;
    logic [ExpWidth-1:0]      a_exp;

    logic                     b_valid;
    logic [ResultWidth-1:0]   b_result;
    logic                     b_over;
    logic                     b_under;
    logic                     b_zero;

    // A stage may move whenever its successor can take its content.
    assign adv_b         = !b_valid || bus.out_ready;
    assign adv_a         = !a_valid || adv_b;
    assign bus.in_ready  = adv_a;
    assign bus.out_valid = b_valid;
    assign bus.result    = b_result;
    assign bus.overflow  = b_over;
    assign bus.underflow = b_under;
    assign bus.zero      = b_zero;

    // Leading-zero count of the raw sum, scanning from the MSB down.
    logic [LzcWidth-1:0] lzc;
    logic                lz_found;
    always_comb begin
        lzc      = '0;
        lz_found = 1'b0;
        for (int i = RoundingSize - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (bus.sum[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lzc = lzc + LzcWidth'(1);
                end
            end
        end
    end

    // Normalization: a carry-out shifts right by one, folding the two lowest
    // bits into the sticky position; otherwise shift left by the LZC.
    // The exponent is one bit wider so neither direction can wrap.
    logic [RoundingSize-1:0] norm;
    logic [ExpWidth-1:0]     norm_exp;
    logic [ExpWidth-1:0]     base_wide;
    logic                    in_zero;
    logic                    in_under;
    always_comb begin
        base_wide = {1'b0, bus.exponent_base};
        in_zero   = !bus.carry && (bus.sum == '0);
        if (bus.carry) begin
            norm     = {1'b1, bus.sum[RoundingSize-1:2], bus.sum[1] | bus.sum[0]};
            norm_exp = base_wide + ExpWidth'(1);
            in_under = 1'b0;
        end else begin
            norm     = bus.sum << lzc;
            norm_exp = base_wide - ExpWidth'(lzc);
            in_under = !in_zero && (base_wide <= ExpWidth'(lzc));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_sign  <= 1'b0;
            a_zero  <= 1'b0;
            a_under <= 1'b0;
            a_norm  <= '0;
            a_exp   <= '0;
        end else if (adv_a) begin
            a_valid <= bus.in_valid;
            if (bus.in_valid) begin
                a_sign  <= bus.result_sign;
                a_zero  <= in_zero;
                a_under <= in_under;
                a_norm  <= norm;
                a_exp   <= norm_exp;
            end
        end
    end

    // Round to nearest even on the 24-bit significand; a carry out of the
    // significand leaves the stored fraction at zero and bumps the exponent.
    // Zero takes priority over underflow, which takes priority over overflow,
    // so only one flag is ever raised.
    logic                    round_up;
    logic [SigWidth:0]       rounded;
    logic [ExpWidth-1:0]     final_exp;
    logic [ResultWidth-1:0]  next_result;
    logic                    next_over;
    logic                    next_under;
    logic                    next_zero;
    always_comb begin
        round_up    = a_norm[2] & (a_norm[1] | a_norm[0] | a_norm[3]);
        rounded     = {1'b0, a_norm[RoundingSize-1:3]} + (SigWidth + 1)'(round_up);
        final_exp   = a_exp + ExpWidth'(rounded[SigWidth]);
        next_result = {a_sign, final_exp[ExponentSize-1:0], rounded[FractionSize-1:0]};
        next_over   = 1'b0;
        next_under  = 1'b0;
        next_zero   = 1'b0;
        if (a_zero) begin
            next_result = '0;
            next_zero   = 1'b1;
        end else if (a_under) begin
            next_result = {a_sign, {(ResultWidth - 1){1'b0}}};
            next_under  = 1'b1;
        end else if (final_exp >= ExpAllOnes) begin
            next_result = {a_sign, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
            next_over   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid  <= 1'b0;
            b_result <= '0;
            b_over   <= 1'b0;
            b_under  <= 1'b0;
            b_zero   <= 1'b0;
        end else if (adv_b) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_result <= next_result;
                b_over   <= next_over;
                b_under  <= next_under;
                b_zero   <= next_zero;
            end
        end
    end
endmodule

// File: tb/tb_add_sub_normalize_round.sv
// tb_add_sub_normalize_round
// Self-checking bench for add_sub_normalize_round: directed corner vectors,
// backpressure, mid-flight reset and randomized traffic checked against an
// exact round-to-nearest-even model of the adder magnitude.
`timescale 1ns/1ps
module tb_add_sub_normalize_round;
    typedef struct packed {
        logic [31:0] r;
        logic        ov;
        logic        un;
        logic        z;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         tests    = 0;
    int         failures = 0;
    int         ready_mode = 1;
    exp_t       exp_q[$];
    logic       held_pending = 1'b0;
    logic [31:0] held_result = '0;
    logic [2:0] held_flags = '0;
    logic [2:0] flags;

    add_sub_normalize_round_if bus();

    add_sub_normalize_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign flags = {bus.overflow, bus.underflow, bus.zero};

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        assert (actual === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic ov, input logic un, input logic z);
        exp_t x;
        x.r  = r;
        x.ov = ov;
        x.un = un;
        x.z  = z;
        return x;
    endfunction

    // Value of the input is (carry:sum) * 2^(base-26) with the significand's
    // leading one at bit 26; round that integer exactly to 24 significant bits.
    function automatic exp_t refModel(input logic [26:0] s, input logic c, input logic [7:0] eb, input logic sg);
        exp_t   x;
        longint m, q, rem, half;
        int     p, e, sh;
        x = '0;
        m = (longint'(c) << 27) | longint'(s);
        if (m == 0) begin
            x.z = 1'b1;
            return x;
        end
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        e = int'(eb) + p - 26;
        if (e <= 0) begin
            x.r  = {sg, 31'b0};
            x.un = 1'b1;
            return x;
        end
        sh = p - 23;
        if (sh > 0) begin
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = m << (-sh);
        end
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) begin
            x.r  = {sg, 8'hFF, 23'h0};
            x.ov = 1'b1;
        end else begin
            x.r = {sg, e[7:0], q[22:0]};
        end
        return x;
    endfunction

    task automatic applyStimulus(input logic [26:0] s, input logic c, input logic [7:0] eb, input logic sg, input exp_t e);
        bit accepted;
        accepted          = 1'b0;
        bus.sum           = s;
        bus.carry         = c;
        bus.exponent_base = eb;
        bus.result_sign   = sg;
        bus.in_valid      = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        checkOutput("accept_timeout", 32'(accepted), 32'd1);
        if (accepted) exp_q.push_back(e);
        else bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic applyRandom();
        logic [26:0] s;
        logic        c;
        logic [7:0]  eb;
        logic        sg;
        s  = 27'($urandom) >> $urandom_range(0, 27);
        c  = ($urandom_range(0, 3) == 0);
        sg = 1'($urandom);
        case ($urandom_range(0, 3))
            0:       eb = 8'($urandom_range(0, 30));
            1:       eb = 8'($urandom_range(225, 255));
            default: eb = 8'($urandom);
        endcase
        applyStimulus(s, c, eb, sg, refModel(s, c, eb, sg));
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        ready_mode   = 1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Downstream readiness: 0 = stall, 1 = always ready, 2 = random.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output monitor: in-order scoreboard plus stability while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_pending = 1'b0;
            end else begin
                if (held_pending) begin
                    checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("hold_result", bus.result, held_result);
                    checkOutput("hold_flags", 32'(flags), 32'(held_flags));
                end
                if (bus.out_valid && bus.out_ready) begin
                    checkOutput("expected_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("result", bus.result, e.r);
                        checkOutput("flags", 32'(flags), 32'({e.ov, e.un, e.z}));
                        checkOutput("flags_exclusive", 32'($countones(flags) <= 1), 32'd1);
                    end
                end
                held_pending = bus.out_valid && !bus.out_ready;
                held_result  = bus.result;
                held_flags   = flags;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.in_valid      = 1'b0;
        bus.sum           = '0;
        bus.carry         = 1'b0;
        bus.exponent_base = '0;
        bus.result_sign   = 1'b0;

        // Reset state.
        #3;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_flags", 32'(flags), 32'd0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Carry-out case and two-cycle latency.
        applyStimulus(27'h0000000, 1'b1, 8'd127, 1'b0, mk(32'h40000000, 0, 0, 0));
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("latency_cycle1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_cycle2", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Directed rounding and flag corners, back to back.
        applyStimulus(27'h4000004, 1'b0, 8'd127, 1'b0, mk(32'h3F800000, 0, 0, 0));
        applyStimulus(27'h400000C, 1'b0, 8'd127, 1'b0, mk(32'h3F800002, 0, 0, 0));
        applyStimulus(27'h7FFFFFC, 1'b0, 8'd127, 1'b0, mk(32'h40000000, 0, 0, 0));
        applyStimulus(27'h0000000, 1'b1, 8'd254, 1'b0, mk(32'h7F800000, 1, 0, 0));
        applyStimulus(27'h0000000, 1'b0, 8'd127, 1'b1, mk(32'h00000000, 0, 0, 1));
        applyStimulus(27'h2000000, 1'b0, 8'd1,   1'b1, mk(32'h80000000, 0, 1, 0));
        drain();

        // Backpressure: two captures fill the pipe, the third waits.
        ready_mode = 0;
        applyStimulus(27'h4000004, 1'b0, 8'd100, 1'b0, refModel(27'h4000004, 1'b0, 8'd100, 1'b0));
        applyStimulus(27'h1234567, 1'b1, 8'd90,  1'b1, refModel(27'h1234567, 1'b1, 8'd90,  1'b1));
        bus.sum           = 27'h0ABCDEF;
        bus.carry         = 1'b0;
        bus.exponent_base = 8'd60;
        bus.result_sign   = 1'b0;
        @(negedge clk);
        checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 1;
        applyStimulus(27'h0ABCDEF, 1'b0, 8'd60, 1'b0, refModel(27'h0ABCDEF, 1'b0, 8'd60, 1'b0));
        drain();

        // Reset with both stages full discards everything in flight.
        ready_mode = 0;
        applyStimulus(27'h3000000, 1'b0, 8'd50, 1'b0, refModel(27'h3000000, 1'b0, 8'd50, 1'b0));
        applyStimulus(27'h5555555, 1'b1, 8'd70, 1'b1, refModel(27'h5555555, 1'b1, 8'd70, 1'b1));
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_result", bus.result, 32'd0);
        checkOutput("midreset_flags", 32'(flags), 32'd0);
        exp_q.delete();
        ready_mode = 1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_midreset", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(27'h1FFFFFF, 1'b0, 8'd200, 1'b0, refModel(27'h1FFFFFF, 1'b0, 8'd200, 1'b0));
        drain();

        // Randomized traffic with random downstream stalls and input gaps.
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            applyRandom();
            if ($urandom_range(0, 4) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/add_sub_normalize_round.md
ADD_SUB_NORMALIZE_ROUND -- requirements
Module: add_sub_normalize_round

Interface
REQ-001 Parameter ExponentSize, default 8, exponent width.
REQ-002 Parameter FractionSize, default 23, stored fraction width.
REQ-003 Parameter RoundingSize, default FractionSize+4 (27), width of the adder result: hidden bit + fraction + guard + round + sticky.
REQ-004 Clk  input  1  sole clock, rising edge.
REQ-005 Rstn  input  1  reset, asynchronous, active-low.
REQ-006 InValid  input  1  upstream adder result valid.
REQ-007 InReady  output  1  block accepts input this cycle.
REQ-008 Sum  input  RoundingSize  adder magnitude output, already un-inverted.
REQ-009 Carry  input  1  adder carry-out.
REQ-010 ExponentBase  input  ExponentSize  larger-operand exponent from the alignment stage.
REQ-011 ResultSign  input  1  sign of the result.
REQ-012 OutValid  output  1  Result valid.
REQ-013 OutReady  input  1  downstream accepts Result.
REQ-014 Result  output  ExponentSize+FractionSize+1  packed IEEE-754 result {sign, exponent, fraction}.
REQ-015 Overflow, Underflow, Zero  output  1 each  status flags, qualified by OutValid.

Function
REQ-016 The block SHALL be a two-register pipeline: stage A (normalize), stage B (round/pack), with valid bits VA and VB.
REQ-017 Handshake: AdvB = !VB | OutReady; AdvA = !VA | AdvB; InReady = AdvA; input is captured when InValid & InReady.
REQ-018 Latency SHALL be 2 cycles from capture to OutValid with OutReady held high; throughput 1 result/cycle.
REQ-019 While OutValid=1 and OutReady=0, Result and flags SHALL hold stable.
REQ-020 Carry=1: normalized N = {1, Sum[RS-1:2], Sum[1]|Sum[0]}; exponent E = ExponentBase+1 (ExponentSize+1 bits).
REQ-021 Carry=0, Sum nonzero: LZC = leading zeros of Sum; N = Sum << LZC; E = ExponentBase - LZC.
REQ-022 Carry=0, Sum=0: Result = all zeros (sign 0), Zero=1.
REQ-023 If Carry=0 and ExponentBase <= LZC: flush to zero, Result = {ResultSign, 0, 0}, Underflow=1.
REQ-024 Rounding (stage B), round-to-nearest-even: L=N[3], G=N[2], R=N[1], S=N[0]; increment N[RS-1:3] when G & (R | S | L).
REQ-025 Rounding carry-out of the 24-bit significand SHALL yield significand 1.0 and E+1.
REQ-026 Final E >= 255 (all ones): Result = {ResultSign, all ones, 0} (infinity), Overflow=1.
REQ-027 At most one of Overflow/Underflow/Zero SHALL be set per result.
REQ-028 Exponent arithmetic SHALL use ExponentSize+1 bits; no silent wrap.

Reset
REQ-029 Rstn low SHALL asynchronously clear VA, VB, OutValid, Result, and all flags to 0.
REQ-030 Reset mid-operation SHALL discard in-flight data; the first result after release comes from the first input captured after release.
REQ-031 InReady SHALL be 1 in the first cycle after reset release.

Verification
REQ-032 Carry=1, Sum=27'h0000000, ExponentBase=127 -> Result 32'h40000000, no flags, 2 cycles later.
REQ-033 Carry=0, Sum=27'h4000004, Exp 127 -> 32'h3F800000 (tie, even, no increment); Sum=27'h400000C -> 32'h3F800002.
REQ-034 Carry=0, Sum=27'h7FFFFFC, Exp 127 -> rounding carry, Result 32'h40000000.
REQ-035 Carry=1, Exp 254 -> 32'h7F800000, Overflow=1; Sum=0, Carry=0 -> 32'h00000000, Zero=1; Exp 1, Sum=27'h2000000, ResultSign=1 -> 32'h80000000, Underflow=1.
REQ-036 Backpressure: three back-to-back inputs, OutReady=0 for 4 cycles -> InReady drops after two captures, first Result held stable, all three delivered in order with none lost or duplicated once OutReady=1.
REQ-037 Rstn pulsed low with VA=VB=1 -> OutValid=0 immediately, no stale result after release.
